// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: input FIFO with valid/ready push, LSB-first serialiser
// with optional odd/even parity and one or two stop bits, frames sent back-to-back.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    // Handshake: a word is taken on a rising edge where in_valid && in_ready;
    // in_ready depends only on the FIFO fill level, never on in_valid.
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   push, pop, empty;
    logic [DATA_BITS-1:0]   head;

    logic [CW-1:0]          baud, baud_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [3:0]             bit_cnt, bit_n;
    logic                   par_bit, par_n;
    logic                   tx_n;

    assign empty      = (count == '0);
    assign in_ready   = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        shift_n = shift;
        bit_n   = bit_cnt;
        par_n   = par_bit;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                pop  = !empty;
            end
            default: begin
                if (baud != '0) begin
                    baud_n = baud - CW'(1);
                end else begin
                    baud_n = RELOAD;
                    case (state)
                        S_START: begin
                            state_n = S_DATA;
                            tx_n    = shift[0];
                            bit_n   = '0;
                        end
                        S_DATA: begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_n = '0;
                                if (PARITY != 0) begin
                                    state_n = S_PARITY;
                                    tx_n    = par_bit;
                                end else begin
                                    state_n = S_STOP;
                                    tx_n    = 1'b1;
                                end
                            end else begin
                                shift_n = shift >> 1;
                                tx_n    = shift[1];
                                bit_n   = bit_cnt + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                        S_STOP: begin
                            if (bit_cnt == LAST_STOP) begin
                                state_n = S_IDLE;
                                tx_n    = 1'b1;
                                pop     = !empty;
                            end else begin
                                bit_n = bit_cnt + 4'd1;
                            end
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        endcase
        // A pop from IDLE or from the final stop cycle starts the next frame with no gap.
        if (pop) begin
            shift_n = head;
            par_n   = (^head) ^ ODD;
            tx_n    = 1'b0;
            baud_n  = RELOAD;
            bit_n   = '0;
            state_n = S_START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            par_bit <= par_n;
            tx      <= tx_n;
            busy    <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four parameterisations share clock and reset,
// expected serial streams are hand-computed frame words.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] data_a  [4];
    logic       valid_a [4];
    logic       ready_a [4];
    logic       tx_a    [4];
    logic       busy_a  [4];
    logic [2:0] cnt_a   [4];

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1 div 4; 1: even parity; 2: odd parity; 3: 7 data bits, 2 stop, div 3
    uart_tx_cfg #(.CLK_DIV(4)) u_n (
        .clk(clk), .rst(rst), .in_data(data_a[0]), .in_valid(valid_a[0]),
        .in_ready(ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .fifo_count(cnt_a[0]));
    uart_tx_cfg #(.CLK_DIV(4), .PARITY(2)) u_e (
        .clk(clk), .rst(rst), .in_data(data_a[1]), .in_valid(valid_a[1]),
        .in_ready(ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .fifo_count(cnt_a[1]));
    uart_tx_cfg #(.CLK_DIV(4), .PARITY(1)) u_o (
        .clk(clk), .rst(rst), .in_data(data_a[2]), .in_valid(valid_a[2]),
        .in_ready(ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .fifo_count(cnt_a[2]));
    uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .STOP_BITS(2)) u_w (
        .clk(clk), .rst(rst), .in_data(data_a[3][6:0]), .in_valid(valid_a[3]),
        .in_ready(ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .fifo_count(cnt_a[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one word into an idle instance and check the whole frame bit by bit.
    task automatic send_frame(input int inst, input logic [7:0] word, input logic [15:0] bits,
                              input int nbits, input int div, input string tag);
        data_a[inst]  = word;
        valid_a[inst] = 1'b1;
        tick();
        valid_a[inst] = 1'b0;
        chk({tag, "_cnt_after_push"}, 16'(cnt_a[inst]), 16'd1);
        chk({tag, "_tx_before_pop"}, 16'(tx_a[inst]), 16'd1);
        chk({tag, "_busy_before_pop"}, 16'(busy_a[inst]), 16'd0);
        tick();
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < div; k++) begin
                chk({tag, "_tx"}, 16'(tx_a[inst]), 16'(bits[b]));
                chk({tag, "_busy"}, 16'(busy_a[inst]), 16'd1);
                tick();
            end
        end
        chk({tag, "_busy_end"}, 16'(busy_a[inst]), 16'd0);
        chk({tag, "_tx_end"}, 16'(tx_a[inst]), 16'd1);
        chk({tag, "_cnt_end"}, 16'(cnt_a[inst]), 16'd0);
    endtask

    // Check contiguous 8N1 frames on instance 0 for every word in exp_q,
    // starting 'skip' cycles into the first frame.
    task automatic check_stream(input int skip);
        logic [9:0] fr;
        logic [7:0] w;
        int s;
        s = skip;
        while (exp_q.size() > 0) begin
            w  = exp_q.pop_front();
            fr = {1'b1, w, 1'b0};
            for (int o = s; o < 40; o++) begin
                chk("stream_tx", 16'(tx_a[0]), 16'(fr[o/4]));
                chk("stream_busy", 16'(busy_a[0]), 16'd1);
                chk("stream_cnt_max", 16'(cnt_a[0] <= 3'd4), 16'd1);
                tick();
            end
            s = 0;
        end
        chk("stream_busy_end", 16'(busy_a[0]), 16'd0);
        chk("stream_tx_end", 16'(tx_a[0]), 16'd1);
        chk("stream_cnt_end", 16'(cnt_a[0]), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_a[i]  = 8'h00;
            valid_a[i] = 1'b0;
        end
        tick();
        tick();
        chk("rst_tx", 16'(tx_a[0]), 16'd1);
        chk("rst_busy", 16'(busy_a[0]), 16'd0);
        chk("rst_cnt", 16'(cnt_a[0]), 16'd0);
        chk("rst_ready", 16'(ready_a[0]), 16'd1);
        chk("rst_tx_w7", 16'(tx_a[3]), 16'd1);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_tx", 16'(tx_a[0]), 16'd1);

        // Single frames: {stop, [parity], data LSB-first, start}
        send_frame(0, 8'hA5, 16'h034A, 10, 4, "8n1_a5");
        send_frame(1, 8'hA5, 16'h054A, 11, 4, "even_a5");
        send_frame(2, 8'hA5, 16'h074A, 11, 4, "odd_a5");
        send_frame(2, 8'h07, 16'h040E, 11, 4, "odd_07");
        send_frame(3, 8'h41, 16'h0382, 10, 3, "w7s2_41");
        tick();

        // FIFO fill with in_valid held high, words 1..6
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h01;
        tick();
        chk("full_cnt_e0", 16'(cnt_a[0]), 16'd1);
        data_a[0] = 8'h02;
        tick();
        chk("full_cnt_e1", 16'(cnt_a[0]), 16'd1);
        chk("full_tx_e1", 16'(tx_a[0]), 16'd0);
        chk("full_busy_e1", 16'(busy_a[0]), 16'd1);
        data_a[0] = 8'h03;
        tick();
        chk("full_cnt_e2", 16'(cnt_a[0]), 16'd2);
        data_a[0] = 8'h04;
        tick();
        chk("full_cnt_e3", 16'(cnt_a[0]), 16'd3);
        data_a[0] = 8'h05;
        tick();
        chk("full_cnt_e4", 16'(cnt_a[0]), 16'd4);
        chk("full_ready_e4", 16'(ready_a[0]), 16'd0);
        data_a[0] = 8'h06;
        for (int c = 5; c <= 40; c++) begin
            tick();
            chk("full_wait_ready", 16'(ready_a[0]), 16'd0);
            chk("full_wait_cnt", 16'(cnt_a[0]), 16'd4);
            chk("full_wait_busy", 16'(busy_a[0]), 16'd1);
        end
        tick();
        chk("full_pop2_cnt", 16'(cnt_a[0]), 16'd3);
        chk("full_pop2_ready", 16'(ready_a[0]), 16'd1);
        chk("full_pop2_tx", 16'(tx_a[0]), 16'd0);
        chk("full_pop2_busy", 16'(busy_a[0]), 16'd1);
        tick();
        valid_a[0] = 1'b0;
        chk("full_push6_cnt", 16'(cnt_a[0]), 16'd4);
        chk("full_push6_ready", 16'(ready_a[0]), 16'd0);
        exp_q = {8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check_stream(1);
        tick();

        // Ignored push: 0xFF offered while full must never be taken
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h11;
        tick();
        data_a[0] = 8'h22;
        tick();
        data_a[0] = 8'h33;
        tick();
        data_a[0] = 8'h44;
        tick();
        data_a[0] = 8'h55;
        tick();
        chk("ign_full_cnt", 16'(cnt_a[0]), 16'd4);
        data_a[0] = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("ign_cnt", 16'(cnt_a[0]), 16'd4);
            chk("ign_ready", 16'(ready_a[0]), 16'd0);
        end
        valid_a[0] = 1'b0;
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_stream(13);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("ign_after_tx", 16'(tx_a[0]), 16'd1);
            chk("ign_after_busy", 16'(busy_a[0]), 16'd0);
        end

        // Reset during data bit 3 (0x52 has bit 3 = 0) with two words queued
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h52;
        tick();
        data_a[0] = 8'h66;
        tick();
        data_a[0] = 8'h77;
        tick();
        valid_a[0] = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        chk("mid_tx_bit3", 16'(tx_a[0]), 16'd0);
        chk("mid_busy", 16'(busy_a[0]), 16'd1);
        chk("mid_cnt", 16'(cnt_a[0]), 16'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 16'(tx_a[0]), 16'd1);
        chk("mid_rst_busy", 16'(busy_a[0]), 16'd0);
        chk("mid_rst_cnt", 16'(cnt_a[0]), 16'd0);
        chk("mid_rst_ready", 16'(ready_a[0]), 16'd1);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            chk("post_rst_tx", 16'(tx_a[0]), 16'd1);
            chk("post_rst_busy", 16'(busy_a[0]), 16'd0);
            chk("post_rst_cnt", 16'(cnt_a[0]), 16'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a small input FIFO. Successor to the fixed 8N1 transmitter: configurable bit period, data width, parity mode and stop-bit count, plus a valid/ready input handshake so producers can queue several bytes. It serialises words LSB-first onto `tx`, sends frames back-to-back while the FIFO holds data, and sits between the system-side data producer and the board-level serial pin.

## Interface
- `CLK_DIV`, 10: clk cycles per serial bit; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_BITS  word to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word; equals `!full`.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high while a frame is on the line (state ≠ IDLE); registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words waiting in the FIFO, not counting the frame in flight.

## Operation
- Push: a word is written on any rising edge where `in_valid && in_ready`. While `in_ready` is low, `in_valid` is ignored and the word is not taken.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. When the FIFO is not empty, pop the head into the shift register, drive `tx`<=0, load the baud counter with CLK_DIV-1, and go to START.
- START → DATA after CLK_DIV cycles. DATA shifts out `DATA_BITS` bits LSB-first, each lasting CLK_DIV cycles.
- After the last data bit, go to PARITY if PARITY≠0, else to STOP.
- PARITY bit: even mode makes the total count of ones over data+parity even; odd mode makes it odd. It is computed from the popped word.
- STOP: `tx`=1 for STOP_BITS×CLK_DIV cycles. At the end of STOP:
  - FIFO not empty: pop the next word and go directly to START, with no idle gap.
  - FIFO empty: go to IDLE.
- Frame length is exactly (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×CLK_DIV cycles.
- Baud counter: down-counter, width $clog2(CLK_DIV). It reloads to CLK_DIV-1 at every bit boundary and never wraps past zero.
- `fifo_count` update on a single edge:
  - Push and pop together: unchanged.
  - Push only: +1.
  - Pop only: -1.
  - When full, no push is possible. A pop on edge E raises `in_ready` in the following cycle.
- When empty, a push and a pop cannot coincide; the pop happens at the earliest on the next edge.
- Reset (async, any time, including mid-frame): the frame is abandoned and the FIFO is emptied. `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1, state = IDLE, counters = 0. Immediately after reset deasserts, `tx` stays high with no partial frame and no glitch.

## Timing
- Latency:
  - Word pushed into an empty FIFO on edge E while IDLE.
  - Pop happens on E+1; `tx` falls and `busy` rises after E+1.
  - Start bit occupies cycles E+1..E+CLK_DIV.
- `busy` falls on the same edge where `tx` would begin idling, i.e. the last STOP cycle ends the frame.
- Back-to-back: between the last stop cycle and the next start bit there are 0 idle cycles.
- `in_ready` is combinational from the FIFO count only; it never depends on `in_valid`.
- `tx` changes only on bit boundaries.

## Test plan
- Basic frame, CLK_DIV=4, 8N1: push 0xA5 once.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles (40 total).
  - `busy` is high for 40 cycles; start bit begins the cycle after E+1.
- Parity, CLK_DIV=4, 8-bit:
  - PARITY=2, word 0xA5: parity bit 0.
  - PARITY=1, word 0xA5: parity bit 1.
  - PARITY=1, word 0x07: parity bit 0.
  - Each frame lasts 44 cycles.
- Width/stop, DATA_BITS=7, STOP_BITS=2, CLK_DIV=3, word 0x41:
  - `tx` = 0,1,0,0,0,0,0,1,1,1.
  - Frame is 30 cycles; stop phase is 6 high cycles.
- FIFO full/back-to-back, FIFO_DEPTH=4:
  - Hold `in_valid` high with 0x01..0x06. The first word pops, 4 more fill the FIFO, then `in_ready`=0 and 0x06 waits.
  - `in_ready` rises one cycle after the next pop, and 0x06 is accepted.
  - All 6 frames appear contiguous, with no idle cycles; `busy` stays high throughout; `fifo_count` never exceeds 4.
- Reset mid-frame: assert `rst` during data bit 3 with 2 words queued.
  - `tx`=1, `busy`=0, `fifo_count`=0 immediately.
  - After release, `tx` stays 1 for 100 cycles with no further frames.
- Ignored push: `in_valid` high while `in_ready`=0 with word 0xFF. That word is never transmitted and `fifo_count` stays unchanged.
